// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and sizing helpers for the wide add sequencer
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width; a single-chunk build still needs one bit of counter.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - N-bit adder with carry in/out, the shared chunk datapath
module adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
    output logic [N-1:0] o_s,
    output logic         o_carry_out
);

    logic [N:0] w_full;

    assign w_full      = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_carry_in};
    assign o_s         = w_full[N-1:0];
    assign o_carry_out = w_full[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - N*K-bit add done one N-bit chunk per cycle on a shared adder
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N = 64,
    parameter int K = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N*K-1:0] i_a,
    input  logic [N*K-1:0] i_b,
    input  logic           i_carry_in,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [N*K-1:0] o_s,
    output logic           o_carry_out
);

    localparam int             IW       = idx_width(K);
    localparam logic [IW-1:0]  LAST_IDX = IW'(K - 1);

    state_t               r_state;
    state_t               w_next;

    logic [K-1:0][N-1:0]  r_a;
    logic [K-1:0][N-1:0]  r_b;
    logic [K-1:0][N-1:0]  r_s;
    logic                 r_carry;
    logic                 r_carry_out;
    logic [IW-1:0]        r_idx;

    logic                 w_accept;
    logic                 w_release;
    logic                 w_last;
    logic [N-1:0]         w_chunk_s;
    logic                 w_chunk_co;

    assign w_accept  = i_valid && o_ready;
    assign w_release = o_valid && i_ready;
    assign w_last    = (r_idx == LAST_IDX);

    adder #(.N(N)) u_adder (
        .i_a         (r_a[r_idx]),
        .i_b         (r_b[r_idx]),
        .i_carry_in  (r_carry),
        .o_s         (w_chunk_s),
        .o_carry_out (w_chunk_co)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (w_release) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Handshake outputs depend only on the state register (and reset for o_ready).
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            IDLE:    o_ready = !i_rst;
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture needs no reset: the copies are only read while in RUN.
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == IDLE && w_accept) begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_carry <= i_carry_in;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_s[r_idx] <= w_chunk_s;
                    r_carry    <= w_chunk_co;
                    if (w_last) begin
                        r_carry_out <= w_chunk_co;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_s         = r_s;
    assign o_carry_out = r_carry_out;

endmodule
